// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: single-cycle pixel enable, horizontal and vertical
// position counters, and registered sync / display-enable / coordinate / strobe outputs.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (XW < $clog2(H_ACTIVE)) begin : g_bad_xw
      $error("vga_timing_gen: XW too narrow for H_ACTIVE");
    end
    if (YW < $clog2(V_ACTIVE)) begin : g_bad_yw
      $error("vga_timing_gen: YW too narrow for V_ACTIVE");
    end
  endgenerate

  logic [DW-1:0] r_div_cnt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_pix_en;
  logic          r_h_sync;
  logic          r_v_sync;
  logic          r_de;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  logic [DW-1:0] w_div_nxt;
  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic          w_adv;
  logic          w_pix_nxt;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_hs_on;
  logic          w_vs_on;
  logic          w_ls_nxt;
  logic          w_fs_nxt;

  // Next divider/position values; outputs are decoded from these so they land with the counters.
  always_comb begin
    w_div_nxt = r_div_cnt;
    w_h_nxt   = r_h_cnt;
    w_v_nxt   = r_v_cnt;
    w_adv     = en && r_pix_en;

    if (r_div_cnt == DIV_LAST) begin
      w_div_nxt = {DW{1'b0}};
    end else begin
      w_div_nxt = r_div_cnt + DW'(1);
    end

    if (w_adv) begin
      if (r_h_cnt == H_LAST) begin
        w_h_nxt = {HW{1'b0}};
        if (r_v_cnt == V_LAST) begin
          w_v_nxt = {VW{1'b0}};
        end else begin
          w_v_nxt = r_v_cnt + VW'(1);
        end
      end else begin
        w_h_nxt = r_h_cnt + HW'(1);
        w_v_nxt = r_v_cnt;
      end
    end else begin
      w_h_nxt = r_h_cnt;
      w_v_nxt = r_v_cnt;
    end
  end

  // Region decode of the next position.
  always_comb begin
    w_pix_nxt = (w_div_nxt == DIV_LAST);
    w_h_act   = (int'(w_h_nxt) < H_ACTIVE);
    w_v_act   = (int'(w_v_nxt) < V_ACTIVE);
    w_hs_on   = (int'(w_h_nxt) >= HS_START) && (int'(w_h_nxt) < HS_END);
    w_vs_on   = (int'(w_v_nxt) >= VS_START) && (int'(w_v_nxt) < VS_END);
    w_ls_nxt  = w_adv && (w_h_nxt == {HW{1'b0}});
    w_fs_nxt  = w_ls_nxt && (w_v_nxt == {VW{1'b0}});
  end

  // State and output registers; a freeze holds everything but clears the strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt     <= {DW{1'b0}};
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_pix_en      <= 1'b0;
      r_h_sync      <= ~HS_POL;
      r_v_sync      <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= {XW{1'b0}};
      r_y           <= {YW{1'b0}};
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (en) begin
      r_div_cnt     <= w_div_nxt;
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_pix_en      <= w_pix_nxt;
      r_h_sync      <= w_hs_on ? HS_POL : ~HS_POL;
      r_v_sync      <= w_vs_on ? VS_POL : ~VS_POL;
      r_de          <= w_h_act && w_v_act;
      r_x           <= w_h_act ? XW'(w_h_nxt) : {XW{1'b0}};
      r_y           <= w_v_act ? YW'(w_v_nxt) : {YW{1'b0}};
      r_line_start  <= w_ls_nxt;
      r_frame_start <= w_fs_nxt;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign pix_en      = r_pix_en;
  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations checked every clock against
// a position model computed from the count of enabled clocks since reset.
module tb_vga_timing_gen;

  localparam int A_D = 2, A_HA = 10, A_HF = 2, A_HS = 3, A_HB = 1;
  localparam int A_VA = 5, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int B_D = 1, B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 3;
  localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int C_D = 2, C_HA = 640, C_HF = 16, C_HS = 96, C_HB = 48;
  localparam int C_VA = 480, C_VF = 10, C_VS = 2, C_VB = 33;
  localparam int A_FRAME = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB) * A_D;
  localparam int B_FRAME = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB) * B_D;
  localparam longint B_POSITIONS = 16 * 7;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  logic a_pix, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [3:0] a_x;
  logic [2:0] a_y;
  logic b_pix, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [2:0] b_x;
  logic [1:0] b_y;
  logic c_pix, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0] c_x;
  logic [8:0] c_y;

  vga_timing_gen #(.CLK_DIV(A_D), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
                   .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .XW(4), .YW(3)) u_a (
    .clk(clk), .rst(rst), .en(en), .pix_en(a_pix), .h_sync(a_hs), .v_sync(a_vs),
    .de(a_de), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.CLK_DIV(B_D), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
                   .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .XW(3), .YW(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .pix_en(b_pix), .h_sync(b_hs), .v_sync(b_vs),
    .de(b_de), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs));

  vga_timing_gen u_c (
    .clk(clk), .rst(rst), .en(en), .pix_en(c_pix), .h_sync(c_hs), .v_sync(c_vs),
    .de(c_de), .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs));

  int     checks = 0;
  int     failures = 0;
  longint n = 0;
  logic   last_en = 1'b0;
  int     cyc = 0;
  int     a_fs_cyc = 0;
  int     b_fs_cnt = 0;
  int     fs1, fs2, lines, start_cyc, fs_before;
  logic   found;

  // Pixel advances completed after nn enabled clocks: the first tick needs one clock to arm.
  function automatic longint adv(longint nn, int d);
    if (d == 1) return (nn > 0) ? nn - 1 : 0;
    return nn / d;
  endfunction

  function automatic longint pos(longint nn, int d, longint total);
    return (total - 1 + adv(nn, d)) % total;
  endfunction

  function automatic logic [31:0] model(int d, int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb,
                                        logic hp, logic vp, longint nn, logic le);
    longint ht, vt, idx, h, v;
    logic pix, ls, fs, hsy, vsy, de_e;
    logic [12:0] xe, ye;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    idx  = pos(nn, d, ht * vt);
    h    = idx % ht;
    v    = idx / ht;
    pix  = (nn >= 1) && ((nn % d) == longint'(d - 1));
    ls   = le && (nn >= 1) && (adv(nn, d) != adv(nn - 1, d)) && (h == 0);
    fs   = ls && (v == 0);
    hsy  = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    vsy  = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    de_e = (h < ha) && (v < va);
    xe   = (h < ha) ? 13'(h) : 13'd0;
    ye   = (v < va) ? 13'(v) : 13'd0;
    return {pix, hsy, vsy, de_e, ls, fs, xe, ye};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    check("cfg_a", {a_pix, a_hs, a_vs, a_de, a_ls, a_fs, 13'(a_x), 13'(a_y)},
          model(A_D, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0, n, last_en));
    check("cfg_b", {b_pix, b_hs, b_vs, b_de, b_ls, b_fs, 13'(b_x), 13'(b_y)},
          model(B_D, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1, n, last_en));
    check("cfg_c", {c_pix, c_hs, c_vs, c_de, c_ls, c_fs, 13'(c_x), 13'(c_y)},
          model(C_D, C_HA, C_HF, C_HS, C_HB, C_VA, C_VF, C_VS, C_VB, 1'b0, 1'b0, n, last_en));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      last_en = en;
      if (en) n++;
    end else begin
      last_en = 1'b0;
    end
    cyc++;
    @(negedge clk);
    check_all();
    if (a_fs) a_fs_cyc = cyc;
    if (b_fs) b_fs_cnt++;
  endtask

  task automatic post_reset_seq();
    step();
    check("edge1_pix_a", a_pix, 1'b1);
    check("edge1_pix_b", b_pix, 1'b1);
    check("edge1_fs_a", a_fs, 1'b0);
    step();
    check("edge2_fs_a", a_fs, 1'b1);
    check("edge2_ls_a", a_ls, 1'b1);
    check("edge2_de_a", a_de, 1'b1);
    check("edge2_fs_b", b_fs, 1'b1);
    check("edge2_fs_c", c_fs, 1'b1);
    step();
    check("edge3_fs_a", a_fs, 1'b0);
    check("edge3_ls_a", a_ls, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    check_all();
    step();
    rst = 1'b1;
    post_reset_seq();

    // Frame period and line count on the CLK_DIV=1 configuration.
    fs1 = -1; fs2 = -1; lines = 0;
    for (int i = 0; i < 400 && fs2 < 0; i++) begin
      step();
      if (b_fs && fs1 >= 0) fs2 = cyc;
      else if (b_fs) fs1 = cyc;
      if (b_ls && fs1 >= 0 && fs2 < 0) lines++;
    end
    check("b_frame_period", fs2 - fs1, B_FRAME);
    check("b_lines_per_frame", lines, 7);

    // Freeze 37 clocks mid-line at x=5 on configuration A.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (a_x == 4'd5 && a_de && a_pix) found = 1'b1;
    end
    check("a_reach_x5", found, 1'b1);
    start_cyc = a_fs_cyc;
    en = 1'b0;
    repeat (37) step();
    check("a_frozen_x", a_x, 4'd5);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      step();
      if (a_fs) found = 1'b1;
    end
    check("a_frame_after_freeze", cyc - start_cyc, A_FRAME + 37);

    // Freeze across the wrap to (0,0) on configuration B.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (pos(n, B_D, B_POSITIONS) == B_POSITIONS - 1) found = 1'b1;
    end
    check("b_reach_wrap", found, 1'b1);
    en = 1'b0;
    fs_before = b_fs_cnt;
    repeat (5) step();
    check("b_no_fs_frozen", b_fs_cnt, fs_before);
    en = 1'b1;
    step();
    check("b_fs_on_resume", b_fs, 1'b1);
    repeat (100) step();
    check("b_fs_once", b_fs_cnt, fs_before + 1);

    // Asynchronous reset in the middle of A's h_sync.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (a_hs == 1'b0) found = 1'b1;
    end
    check("a_reach_hsync", found, 1'b1);
    #2;
    rst = 1'b0;
    n = 0;
    last_en = 1'b0;
    #1;
    check_all();
    check("async_rst_hs_a", a_hs, 1'b1);
    check("async_rst_hs_b", b_hs, 1'b0);
    step();
    rst = 1'b1;
    post_reset_seq();

    // Randomised enable pattern with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        n = 0;
        last_en = 1'b0;
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator that drives the display port of the console and supplies pixel coordinates to the picture-generation logic. It replaces the fixed 640x480@60 generator: all horizontal and vertical intervals, sync polarities and the system-clock-to-pixel ratio are parameters. The pixel rate is a single-cycle clock enable, not a derived clock. The block adds display-enable, line/frame strobes and a run/freeze control. Everything runs in the `clk` domain.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; must be ≥1. Value 1 gives `pix_en` permanently high after the first tick.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HS_POL`, 0: asserted level of `h_sync` (0 = active-low).
- `VS_POL`, 0: asserted level of `v_sync`.
- `XW`, 10: width of `x`; must be ≥ clog2(`H_ACTIVE`).
- `YW`, 9: width of `y`; must be ≥ clog2(`V_ACTIVE`).

Ports:
- `clk`, in, 1: system clock (50 MHz in the console).
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: run enable. Low freezes the divider, the counters and all outputs.
- `pix_en`, out, 1: pixel clock enable; high for 1 clk out of every `CLK_DIV`.
- `h_sync`, out, 1: horizontal sync, polarity `HS_POL`.
- `v_sync`, out, 1: vertical sync, polarity `VS_POL`.
- `de`, out, 1: display enable; high inside the visible area.
- `x`, out, XW: visible column. Equals 0 when the horizontal position is outside the active area.
- `y`, out, YW: visible row. Equals 0 when the vertical position is outside the active area.
- `line_start`, out, 1: 1-clk strobe when `h_cnt` enters 0.
- `frame_start`, out, 1: 1-clk strobe when (`h_cnt`, `v_cnt`) enters (0, 0).

## Operation
Derived totals:
- H_TOTAL = `H_ACTIVE` + `H_FP` + `H_SYNC` + `H_BP` (default 800).
- V_TOTAL is the sum of the four vertical intervals (default 525).
- Counter widths are derived with clog2.
- Elaboration fails if `CLK_DIV` < 1 or if `XW` or `YW` is too narrow.

Divider:
- `div_cnt` counts 0..`CLK_DIV`-1 and advances on every clk while `en`=1.
- `pix_en` is registered and is high exactly while `div_cnt` = `CLK_DIV`-1.

Position counters (advance only on an edge where `pix_en`=1 and `en`=1):
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0.
- On that wrap, `v_cnt` increments, wrapping from V_TOTAL-1 to 0.
- Horizontal regions: 0..H_ACTIVE-1 is active. The front porch follows, then sync at [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], then the back porch.
- Vertical regions follow the same layout. With defaults, hsync covers h_cnt 656..751 and vsync covers v_cnt 490..491.

Outputs:
- All outputs are registered and decoded from the *next* counter value, so they are aligned with the counters with zero lag.
- `de` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- `x` and `y` follow the Interface definitions: each is 0 outside its active range.
- `line_start` is high for the single clk after the advance that loads h_cnt=0.
- `frame_start` is high for the single clk after the advance that loads h_cnt=0 and v_cnt=0, and coincides with `line_start`.

Reset (async assert, sync release):
- div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
- `pix_en`=0, `de`=0, `x`=0, `y`=0, `line_start`=0, `frame_start`=0.
- `h_sync` and `v_sync` are at their inactive levels (inactive because the reset position lies in the back porch).
- Reset mid-frame returns to this state immediately with no partial-strobe glitch.

`en`=0:
- All registers hold and strobes are forced to 0.
- On re-enable, counting resumes from the held position.
- A strobe pending at freeze is lost, not replayed.

## Timing
- After `rst` release with `en`=1 and `CLK_DIV`=2:
  - edge 1: `pix_en`=1.
  - edge 2: position becomes (0,0); `de`=1, `x`=0, `y`=0, `frame_start`=1, `line_start`=1.
  - edge 3: strobes return to 0.
- Outputs are stable for `CLK_DIV` clks between advances. Consumers sample on `pix_en`.
- Line period = H_TOTAL×`CLK_DIV` clks (1600 default). Frame period = V_TOTAL×line period (840000 clks).
- `h_sync` asserts on the advance into h_cnt = H_ACTIVE+H_FP and deasserts on the advance into h_cnt = H_ACTIVE+H_FP+H_SYNC.
- `v_sync` changes on the same advance that wraps `h_cnt` to 0.

## Test plan
- Reset release, defaults, `en`=1 → first `frame_start` at edge 2; period between `frame_start` pulses is 840000 clks; exactly 525 `line_start` pulses per frame.
- Default frame → per line: `de` high for 640 `pix_en` ticks with `x` 0..639; `h_sync` low for 96 ticks starting 16 ticks after `de` falls. Per frame: `v_sync` low for lines 490..491; `y` reaches 479 and then reads 0 during vertical blanking.
- `CLK_DIV`=1, H 8/2/3/3, V 4/1/1/1, `HS_POL`=`VS_POL`=1 → `pix_en` constant 1 after edge 1; `h_sync` high for h_cnt 10..12; frame period 16×7 = 112 clks.
- `en` low for 37 clks mid-line at x=300 → all outputs frozen and no strobes; counting resumes at x=300 and the frame is 37 clks longer.
- `rst` asserted mid-`h_sync` → outputs take their reset values immediately (asynchronously, no clk needed); sequence after release matches the first scenario.
- `en`=0 held during the tick that would wrap to (0,0) → `frame_start` is not issued; after release it fires exactly once, on that wrap.
